// File: rtl/rx_pkg.sv
// Shared definitions for the serial receive path: FSM states, bit-order
// constants and the bit-counter width helper.
package rx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam bit LSB_FIRST_C = 1'b1;
  localparam bit MSB_FIRST_C = 1'b0;

  // Counter width able to index every bit of a w-bit word.
  function automatic int unsigned count_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop bank with selectable reset style and polarity.
module dff #(
  parameter int unsigned WIDTH          = 1,
  parameter bit          ASYNC_RESET    = 1'b1,
  parameter bit          RESET_POLARITY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (ASYNC_RESET && RESET_POLARITY) begin : g_async_hi
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
      end
    end else if (ASYNC_RESET) begin : g_async_lo
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (rst == RESET_POLARITY) q <= '0;
        else if (en)               q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel word receiver with a one-word valid/ready
// output buffer and sticky overrun / frame-error flags.
module serial_deserializer
  import rx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = LSB_FIRST_C
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  input  logic             i_frame_start,
  input  logic             i_ready,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_frame_err
);

  localparam int unsigned   CW        = count_width(WIDTH);
  localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST_POS = LSB_FIRST ? '0 : LAST;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;

  logic [CW-1:0]    pos_c;
  logic [WIDTH-1:0] word_c;
  logic             take_c;
  logic             restart_c;
  logic             complete_c;
  logic             load_c;
  logic             drop_c;

  // Shift register image with the current bit inserted at its slot.
  always_comb begin
    pos_c      = i_frame_start ? FIRST_POS : (LSB_FIRST ? count : LAST - count);
    word_c     = shreg;
    word_c[pos_c] = i_bit;
    take_c     = i_bit_valid && (i_frame_start || state == SHIFT);
    restart_c  = i_bit_valid && i_frame_start && state == SHIFT;
    complete_c = i_bit_valid && !i_frame_start && state == SHIFT && count == LAST;
    load_c     = complete_c && (!o_valid || i_ready);
    drop_c     = complete_c && !load_c;
  end

  // Receive FSM, bit counter and shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else if (take_c) begin
      shreg <= word_c;
      if (i_frame_start) begin
        state <= SHIFT;
        count <= CW'(1);
      end else if (count == LAST) begin
        state <= IDLE;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Output handshake flag and sticky errors; a set beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (load_c)                  o_valid <= 1'b1;
      else if (o_valid && i_ready) o_valid <= 1'b0;

      if (drop_c)         o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;

      if (restart_c)      o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;
    end
  end

  assign o_busy = (state == SHIFT);

  dff #(
    .WIDTH         (WIDTH),
    .ASYNC_RESET   (1'b1),
    .RESET_POLARITY(1'b1)
  ) u_data (
    .clk(i_clk),
    .rst(i_rst),
    .en (load_c),
    .d  (word_c),
    .q  (o_data)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer; an LSB-first and an
// MSB-first instance share one stimulus stream and one frame-level model.
module tb_serial_deserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         ready = 1'b0;
  logic         clr_err = 1'b0;

  logic [W-1:0] data_l, data_m;
  logic         valid_l, busy_l, ovr_l, ferr_l;
  logic         valid_m, busy_m, ovr_m, ferr_m;

  int checks = 0;
  int failures = 0;

  // Model: bits of the frame in progress, plus output buffer contents.
  bit           m_bits[$];
  bit           m_inframe;
  logic [W-1:0] m_data_l, m_data_m;
  bit           m_valid, m_ovr, m_ferr;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_bit(bit_in), .i_bit_valid(bit_valid),
    .i_frame_start(frame_start), .i_ready(ready), .i_clr_err(clr_err),
    .o_data(data_l), .o_valid(valid_l), .o_busy(busy_l),
    .o_overrun(ovr_l), .o_frame_err(ferr_l)
  );

  serial_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_bit(bit_in), .i_bit_valid(bit_valid),
    .i_frame_start(frame_start), .i_ready(ready), .i_clr_err(clr_err),
    .o_data(data_m), .o_valid(valid_m), .o_busy(busy_m),
    .o_overrun(ovr_m), .o_frame_err(ferr_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_inframe = 1'b0;
    m_data_l  = '0;
    m_data_m  = '0;
    m_valid   = 1'b0;
    m_ovr     = 1'b0;
    m_ferr    = 1'b0;
  endtask

  // Expected state after one clock edge with the given inputs.
  task automatic model_edge(input bit b, input bit bv, input bit fs, input bit rdy, input bit clr);
    bit complete = 1'b0;
    bit restart  = 1'b0;
    bit xfer     = m_valid && rdy;
    logic [W-1:0] wl = '0;
    logic [W-1:0] wm = '0;
    if (bv) begin
      if (fs) begin
        restart = m_inframe;
        m_bits.delete();
        m_bits.push_back(b);
        m_inframe = 1'b1;
      end else if (m_inframe) begin
        m_bits.push_back(b);
        if (m_bits.size() == W) begin
          complete = 1'b1;
          for (int i = 0; i < W; i++) begin
            wl[i]       = m_bits[i];
            wm[W-1-i]   = m_bits[i];
          end
          m_bits.delete();
          m_inframe = 1'b0;
        end
      end
    end
    if (complete && (!m_valid || rdy)) begin
      m_valid  = 1'b1;
      m_data_l = wl;
      m_data_m = wm;
    end else begin
      if (complete) m_ovr = 1'b1;
      if (xfer) m_valid = 1'b0;
    end
    if (clr) begin
      if (!(complete && !xfer && m_valid && !rdy)) m_ovr = m_ovr && complete && !rdy && !xfer ? m_ovr : 1'b0;
    end
    if (restart) m_ferr = 1'b1;
    else if (clr) m_ferr = 1'b0;
  endtask

  task automatic check_all();
    check("data_lsb",  32'(data_l),  32'(m_data_l));
    check("data_msb",  32'(data_m),  32'(m_data_m));
    check("valid",     32'(valid_l), 32'(m_valid));
    check("valid_msb", 32'(valid_m), 32'(m_valid));
    check("busy",      32'(busy_l),  32'(m_inframe));
    check("busy_msb",  32'(busy_m),  32'(m_inframe));
    check("overrun",   32'(ovr_l),   32'(m_ovr));
    check("ovr_msb",   32'(ovr_m),   32'(m_ovr));
    check("frame_err", 32'(ferr_l),  32'(m_ferr));
    check("ferr_msb",  32'(ferr_m),  32'(m_ferr));
  endtask

  task automatic step(input bit b, input bit bv, input bit fs, input bit rdy, input bit clr);
    @(negedge clk);
    bit_in = b; bit_valid = bv; frame_start = fs; ready = rdy; clr_err = clr;
    model_edge(b, bv, fs, rdy, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit gap);
    for (int i = 0; i < W; i++) begin
      step(w[i], 1'b1, i == 0, rdy, 1'b0);
      if (gap) step(1'b1, 1'b0, 1'b1, rdy, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_data",  32'(data_l),  32'h0);
    check("rst_valid", 32'(valid_l), 32'h0);
    check("rst_busy",  32'(busy_l),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Stream 0,1,1,1,1,0,0,0: LSB-first 0x1E, MSB-first 0x78.
    send_word(8'h1E, 1'b1, 1'b0);
    check("lsb_word", 32'(data_l), 32'h1E);
    check("msb_word", 32'(data_m), 32'h78);
    check("valid_up", 32'(valid_l), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("valid_1cyc", 32'(valid_l), 32'h0);

    // Overrun with consumer stalled, then drain and clear.
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    check("ovr_keep", 32'(data_l), 32'hA5);
    check("ovr_set",  32'(ovr_l),  32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_drain", 32'(valid_l), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_clr", 32'(ovr_l), 32'h0);

    // Restart after 4 bits, then a full 0x81 word.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
    check("no_early_word", 32'(valid_l), 32'h0);
    send_word(8'h81, 1'b1, 1'b0);
    check("restart_err",  32'(ferr_l), 32'h1);
    check("restart_word", 32'(data_l), 32'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Stray bits outside a frame, then a gapped word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("idle_ignored", 32'(busy_l), 32'h0);
    send_word(8'h5B, 1'b1, 1'b1);
    check("gap_word", 32'(data_l), 32'h5B);

    // Async reset mid-word with a word pending.
    send_word(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(valid_l), 32'h1);
    check("pre_rst_busy",  32'(busy_l),  32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_data",  32'(data_l),  32'h0);
    check("arst_valid", 32'(valid_l), 32'h0);
    check("arst_busy",  32'(busy_l),  32'h0);
    check("arst_ovr",   32'(ovr_l),   32'h0);
    check("arst_ferr",  32'(ferr_l),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("arst_resume", 32'(busy_l), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit bv;
      bv = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), bv, bv && ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 30) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
